// File: rtl/a2d_sched.sv
// Round-robin A2D conversion scheduler: left load cell, right load cell, battery, once per PERIOD.
// Define A2D_FILT_EN to IIR-filter the two load-cell results (batt is always raw).
module a2d_sched #(
  parameter logic [19:0] PERIOD  = 20'd1_000_000,
  parameter logic [15:0] TIMEOUT = 16'd4096,
  parameter logic [2:0]  CH_LFT  = 3'd0,
  parameter logic [2:0]  CH_RGHT = 3'd4,
  parameter logic [2:0]  CH_BATT = 3'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        vld,
  output logic        err
);

  typedef enum logic [2:0] {StIdle, StSel, StWsel, StRd, StWrd, StStore, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [19:0] timer_q, timer_d;
  logic [15:0] wait_q, wait_d;
  logic [11:0] sample_q, sample_d;
  logic        wrt_q, wrt_d;
  logic [15:0] cmd_q, cmd_d;
  logic [11:0] lft_q, lft_d, rght_q, rght_d, batt_q, batt_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;
  logic [2:0]  ch;
  logic        wrap;
  logic [11:0] lft_new, rght_new;
  logic        unused_hi;

  // Upper nibble of the readback is the ADC's leading zeros / address echo.
  assign unused_hi = ^rd_data[15:12];

`ifdef A2D_FILT_EN
  logic first_q, first_d;

  function automatic logic [11:0] filt(input logic [11:0] old_v, input logic [11:0] smp);
    logic signed [12:0] diff;
    logic signed [12:0] sum;
    diff = $signed({1'b0, smp}) - $signed({1'b0, old_v});
    sum  = $signed({1'b0, old_v}) + (diff >>> 2);
    return sum[11:0];
  endfunction

  assign lft_new  = first_q ? sample_q : filt(lft_q, sample_q);
  assign rght_new = first_q ? sample_q : filt(rght_q, sample_q);
`else
  assign lft_new  = sample_q;
  assign rght_new = sample_q;
`endif

  always_comb begin
    case (idx_q)
      2'd0:    ch = CH_LFT;
      2'd1:    ch = CH_RGHT;
      default: ch = CH_BATT;
    endcase
  end

  assign wrap = (timer_q == PERIOD - 20'd1);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    timer_d  = wrap ? 20'd0 : timer_q + 20'd1;
    wait_d   = wait_q;
    sample_d = sample_q;
    wrt_d    = 1'b0;
    cmd_d    = cmd_q;
    lft_d    = lft_q;
    rght_d   = rght_q;
    batt_d   = batt_q;
    vld_d    = 1'b0;
    err_d    = err_q;
`ifdef A2D_FILT_EN
    first_d  = first_q;
`endif
    case (state_q)
      StIdle: begin
        idx_d = 2'd0;
        if (wrap) state_d = StSel;
      end
      StSel, StRd: begin
        wrt_d   = 1'b1;
        cmd_d   = {2'b00, ch, 11'h000};
        wait_d  = 16'd0;
        state_d = (state_q == StSel) ? StWsel : StWrd;
      end
      StWsel, StWrd: begin
        if (done) begin
          if (state_q == StWrd) sample_d = rd_data[11:0];
          state_d = (state_q == StWsel) ? StRd : StStore;
        end else if (wait_q == TIMEOUT - 16'd1) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      StStore: begin
        case (idx_q)
          2'd0:    lft_d  = lft_new;
          2'd1:    rght_d = rght_new;
          default: batt_d = sample_q;
        endcase
        if (idx_q < 2'd2) begin
          idx_d   = idx_q + 2'd1;
          state_d = StSel;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        vld_d   = 1'b1;
        state_d = StIdle;
`ifdef A2D_FILT_EN
        first_d = 1'b0;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= 2'd0;
      timer_q  <= 20'd0;
      wait_q   <= 16'd0;
      sample_q <= 12'd0;
      wrt_q    <= 1'b0;
      cmd_q    <= 16'd0;
      lft_q    <= 12'd0;
      rght_q   <= 12'd0;
      batt_q   <= 12'd0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef A2D_FILT_EN
      first_q  <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      wait_q   <= wait_d;
      sample_q <= sample_d;
      wrt_q    <= wrt_d;
      cmd_q    <= cmd_d;
      lft_q    <= lft_d;
      rght_q   <= rght_d;
      batt_q   <= batt_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
`ifdef A2D_FILT_EN
      first_q  <= first_d;
`endif
    end
  end

  assign wrt     = wrt_q;
  assign cmd     = cmd_q;
  assign lft_ld  = lft_q;
  assign rght_ld = rght_q;
  assign batt    = batt_q;
  assign vld     = vld_q;
  assign err     = err_q;

endmodule

// File: tb/tb_a2d_sched.sv
// Bench for a2d_sched: transaction-level scheduler model plus an SPI slave model,
// compared every cycle, with a few hand-computed literal checks.
module tb_a2d_sched;

  localparam int PI = 64;
  localparam int TI = 40;

  logic        clk, rst, done;
  logic [15:0] rd_data;
  logic        wrt, vld, err;
  logic [15:0] cmd;
  logic [11:0] lft_ld, rght_ld, batt;

  a2d_sched #(
    .PERIOD (20'(PI)),
    .TIMEOUT(16'(TI))
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .done   (done),
    .rd_data(rd_data),
    .wrt    (wrt),
    .cmd    (cmd),
    .lft_ld (lft_ld),
    .rght_ld(rght_ld),
    .batt   (batt),
    .vld    (vld),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Slave configuration
  int lat_min = 1, lat_max = 3;
  bit never_done = 1'b0;
  int data_mode = 0;  // 0 random, 1 fixed 123/456/789, 2 lft 0 then 400
  int filt_n = 0;
  int sl_ctr = -1;

  // Reference model of the schedule
  int chv[3] = '{0, 4, 5};
  int cyc = 0, m_t = 0;
  bit m_busy = 0, m_out = 0, m_first = 1;
  int m_phase = 0, m_next_wrt = -1, m_wstart = 0, m_vld_at = -1, m_idle_from = 0;
  int m_err_at = -1;
  bit exp_err = 0;
  logic [15:0] exp_cmd = '0;
  int exp_reg[3] = '{0, 0, 0};
  int pend_val[3] = '{0, 0, 0};
  int pend_at[3] = '{-1, -1, -1};
  int vld_cnt = 0;
  logic [15:0] cmd_log[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] gen_data();
    int ch;
    logic [11:0] v;
    ch = m_phase / 2;
    v  = 12'($urandom);
    if (data_mode == 1) v = (ch == 0) ? 12'h123 : (ch == 1) ? 12'h456 : 12'h789;
    if (data_mode == 2 && ch == 0) v = (filt_n == 0) ? 12'h000 : 12'h400;
    return {4'($urandom), v};
  endfunction

  task automatic model_loop();
    bit e_wrt, e_vld;
    int v, idx;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (pend_at[i] == cyc) begin
          exp_reg[i] = pend_val[i];
          pend_at[i] = -1;
        end
      if (m_err_at == cyc) exp_err = 1'b1;
      e_wrt = (m_next_wrt == cyc);
      e_vld = (m_vld_at == cyc);
      if (e_wrt) exp_cmd = 16'(chv[m_phase / 2] << 11);
      chk("wrt", {15'd0, wrt}, {15'd0, e_wrt});
      chk("vld", {15'd0, vld}, {15'd0, e_vld});
      chk("err", {15'd0, err}, {15'd0, exp_err});
      chk("lft_ld", {4'd0, lft_ld}, 16'(exp_reg[0]));
      chk("rght_ld", {4'd0, rght_ld}, 16'(exp_reg[1]));
      chk("batt", {4'd0, batt}, 16'(exp_reg[2]));
      if (e_wrt || m_out) chk("cmd", cmd, exp_cmd);
      if (wrt === 1'b1) cmd_log.push_back(cmd);
      if (vld === 1'b1) vld_cnt++;

      // SPI slave: done arrives a random latency after each wrt
      done = 1'b0;
      if (rst) sl_ctr = -1;
      else begin
        if (sl_ctr > 0) begin
          sl_ctr--;
          if (sl_ctr == 0) begin
            done    = 1'b1;
            rd_data = gen_data();
            sl_ctr  = -1;
          end
        end
        if (wrt === 1'b1) sl_ctr = never_done ? -1 : int'($urandom_range(lat_max, lat_min));
      end

      if (rst) begin
        m_busy = 0; m_out = 0; m_first = 1; m_next_wrt = -1; m_vld_at = -1; m_err_at = -1;
        exp_err = 0; exp_cmd = '0; m_idle_from = cyc + 1; m_t = 0;
        for (int i = 0; i < 3; i++) begin
          exp_reg[i] = 0;
          pend_at[i] = -1;
        end
      end else begin
        if (e_wrt) begin
          m_out = 1; m_wstart = cyc; m_next_wrt = -1;
        end
        if (m_out && done) begin
          m_out = 0;
          if (m_phase % 2 == 1) begin
            idx = m_phase / 2;
            v = int'(rd_data[11:0]);
`ifdef A2D_FILT_EN
            if (idx < 2 && !m_first) v = exp_reg[idx] + ((v - exp_reg[idx]) >>> 2);
`endif
            pend_val[idx] = v;
            pend_at[idx]  = cyc + 2;
            if (idx == 0 && data_mode == 2) filt_n++;
          end
          if (m_phase % 2 == 0) m_next_wrt = cyc + 2;
          else if (m_phase < 5) m_next_wrt = cyc + 3;
          else begin
            m_vld_at = cyc + 3; m_busy = 0; m_idle_from = cyc + 3; m_first = 0;
          end
          m_phase++;
        end else if (m_out && (cyc - m_wstart == TI - 1)) begin
          m_out = 0; m_busy = 0; m_err_at = cyc + 1; m_idle_from = cyc + 1;
        end
        if (!m_busy && cyc >= m_idle_from && m_t == PI - 1) begin
          m_busy = 1; m_phase = 0; m_next_wrt = cyc + 2;
        end
        m_t = (m_t == PI - 1) ? 0 : m_t + 1;
      end
      cyc++;
    end
  endtask

  task automatic wait_vld(input int bound, input string name);
    int k;
    k = 0;
    while (vld !== 1'b1 && k < bound) begin
      @(posedge clk); #2;
      k++;
    end
    n_cmp++;
    if (k >= bound) begin
      n_fail++;
      $display("FAIL %s: vld not seen, got timeout after %0d cycles, required a pulse", name, k);
    end
    @(posedge clk); #2;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  int k0, vc0;
  int filt_exp[4];
  logic [15:0] lit_cmd[6];

  initial begin
    rst = 1'b1; done = 1'b0; rd_data = '0;
    lit_cmd = '{16'h0000, 16'h0000, 16'h2000, 16'h2000, 16'h2800, 16'h2800};
    fork
      model_loop();
    join_none
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_wrt", {15'd0, wrt}, 16'd0);
    chk("rst_vld", {15'd0, vld}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_cmd", cmd, 16'd0);
    chk("rst_lft", {4'd0, lft_ld}, 16'd0);

    // Fixed readback values and command order
    data_mode = 1;
    wait_vld(200, "round1");
    chk("lit_lft", {4'd0, lft_ld}, 16'h0123);
    chk("lit_rght", {4'd0, rght_ld}, 16'h0456);
    chk("lit_batt", {4'd0, batt}, 16'h0789);
    chk("lit_vld_cnt", 16'(vld_cnt), 16'd1);
    chk("lit_wrt_cnt", 16'(cmd_log.size()), 16'd6);
    for (int i = 0; i < 6 && i < cmd_log.size(); i++) chk("lit_cmd_seq", cmd_log[i], lit_cmd[i]);

    // Timeout: slave never answers
    data_mode = 0; never_done = 1'b1; vc0 = vld_cnt;
    k0 = 0;
    while (err !== 1'b1 && k0 < 300) begin
      @(posedge clk); #2;
      k0++;
    end
    chk("lit_err", {15'd0, err}, 16'd1);
    chk("lit_to_vld", 16'(vld_cnt), 16'(vc0));
    chk("lit_to_lft", {4'd0, lft_ld}, 16'h0123);
    never_done = 1'b0;
    wait_vld(200, "after_timeout");

    // Random data, fast slave
    lat_min = 1; lat_max = 6;
    repeat (8) wait_vld(200, "random");

    // Reset while waiting on the right-cell readback
    k0 = 0;
    while (!(m_out && m_phase == 3) && k0 < 300) begin
      @(posedge clk); #2;
      k0++;
    end
    pulse_rst();
    chk("mid_rst_lft", {4'd0, lft_ld}, 16'd0);
    chk("mid_rst_batt", {4'd0, batt}, 16'd0);
    chk("mid_rst_err", {15'd0, err}, 16'd0);
    chk("mid_rst_wrt", {15'd0, wrt}, 16'd0);
    wait_vld(200, "after_rst");

    // Slow slave: rounds longer than PERIOD, wraps in-round are dropped
    lat_min = 10; lat_max = 25;
    repeat (4) wait_vld(400, "slow");

    // Load-cell filter sequence
    lat_min = 1; lat_max = 3;
    pulse_rst();
    data_mode = 2; filt_n = 0;
`ifdef A2D_FILT_EN
    filt_exp = '{'h000, 'h100, 'h1C0, 'h250};
`else
    filt_exp = '{'h000, 'h400, 'h400, 'h400};
`endif
    for (int r = 0; r < 4; r++) begin
      wait_vld(200, "filt_round");
      chk("lit_filt_lft", {4'd0, lft_ld}, 16'(filt_exp[r]));
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
